// File: rtl/cont_read_arbiter_pkg.sv
// Shared definitions for the controller read-port arbiter: FSM state
// encodings, default parameter values and a small index-width helper.
package cont_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int DEFAULT_N_REQ   = 4;
  localparam int DEFAULT_DW      = 32;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_TO_W    = 8;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cont_read_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector. Returns the first set
// request bit at or above ptr, wrapping from N_REQ-1 back to 0, as both a
// one-hot vector and a binary index. Outputs are zero when req is zero.
module rr_pick
  import cont_read_arbiter_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    winner_idx
);

  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] upper_req;
  logic [N_REQ-1:0] src;

  // Positions at or above the pointer take priority over the wrapped ones.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign upper_req = req & upper_mask;
  assign src       = (|upper_req) ? upper_req : req;
  // Isolate the lowest set bit of the chosen search window.
  assign winner    = src & (~src + N_REQ'(1));

  // Encode the one-hot winner into a binary index.
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) winner_idx = winner_idx | IW'(i);
    end
  end

endmodule

// File: rtl/cont_read_arbiter.sv
// cont_read_arbiter: round-robin arbiter sharing the controller read port.
// One transaction at a time: IDLE -> ISSUE (contREAD strobe) -> WAIT (for
// contWRITE) -> RELEASE (VALID pulse) -> IDLE.
// Optional feature macro: CONT_ARB_TIMEOUT_EN adds a WAIT timeout that
// completes the transaction with all-ones data and an ERR pulse.
module cont_read_arbiter
  import cont_read_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEFAULT_N_REQ,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = DEFAULT_TO_W
) (
  input  logic             SYSCLK,
  input  logic             SYSRESET,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [N_REQ-1:0] VALID,
  output logic [DW-1:0]    RDATA_OUT,
  output logic             BUSY,
  output logic             ERR,
  output logic             contREAD,
  input  logic             contWRITE,
  input  logic [DW-1:0]    RDATA
);

  localparam int IW = idx_width(N_REQ);

  state_t           state_reg;
  state_t           state_next;
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] gnt_reg;
  logic [IW-1:0]    idx_reg;
  logic [IW-1:0]    ptr_reg;
  logic [DW-1:0]    rdata_reg;
  logic             in_txn;
  logic             timeout_hit;
  logic             err_flag;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req        (REQ),
    .ptr        (ptr_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  // A response is only accepted while the read is outstanding.
  assign in_txn = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);

`ifdef CONT_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt_reg;
  logic            err_reg;

  // Timeout fires on the WAIT cycle where the counter would reach TIMEOUT;
  // a response in that same cycle takes precedence.
  assign timeout_hit = (state_reg == ST_WAIT) && !contWRITE &&
                       ((cnt_reg + TO_W'(1)) == TO_W'(TIMEOUT));
  assign err_flag    = err_reg;

  // WAIT cycle counter (cleared while issuing) and the error flag for RELEASE.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + TO_W'(1);
      end
      if (in_txn) begin
        err_reg <= timeout_hit;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign err_flag           = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT, TO_W};
`endif

  // State register.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; contWRITE outside ISSUE/WAIT is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (|REQ) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = contWRITE ? ST_RELEASE : ST_WAIT;
      ST_WAIT:    if (contWRITE || timeout_hit) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state so reset clears them at once.
  always_comb begin
    BUSY     = (state_reg != ST_IDLE);
    GNT      = (state_reg != ST_IDLE) ? gnt_reg : '0;
    contREAD = (state_reg == ST_ISSUE);
    VALID    = (state_reg == ST_RELEASE) ? gnt_reg : '0;
    ERR      = (state_reg == ST_RELEASE) && err_flag;
  end

  // Winner capture, read-data capture and round-robin pointer advance.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      gnt_reg   <= '0;
      idx_reg   <= '0;
      ptr_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (|REQ)) begin
        gnt_reg <= pick_onehot;
        idx_reg <= pick_idx;
      end
      if (in_txn && contWRITE) begin
        rdata_reg <= RDATA;
      end else if (timeout_hit) begin
        rdata_reg <= '1;
      end
      if (state_reg == ST_RELEASE) begin
        ptr_reg <= (idx_reg == IW'(N_REQ - 1)) ? '0 : idx_reg + IW'(1);
      end
    end
  end

  assign RDATA_OUT = rdata_reg;

endmodule

// File: tb/tb_cont_read_arbiter.sv
// Self-checking bench for cont_read_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model. Honours CONT_ARB_TIMEOUT_EN like the design.
module tb_cont_read_arbiter;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 5;
  localparam int TO_W    = 8;
`ifdef CONT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          SYSCLK = 1'b0;
  logic          SYSRESET = 1'b1;
  logic [N-1:0]  REQ = '0;
  logic          contWRITE = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic [N-1:0]  GNT;
  logic [N-1:0]  VALID;
  logic [DW-1:0] RDATA_OUT;
  logic          BUSY;
  logic          ERR;
  logic          contREAD;

  int vectors = 0;
  int miscompares = 0;

  cont_read_arbiter #(
    .N_REQ   (N),
    .DW      (DW),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .SYSCLK    (SYSCLK),
    .SYSRESET  (SYSRESET),
    .REQ       (REQ),
    .GNT       (GNT),
    .VALID     (VALID),
    .RDATA_OUT (RDATA_OUT),
    .BUSY      (BUSY),
    .ERR       (ERR),
    .contREAD  (contREAD),
    .contWRITE (contWRITE),
    .RDATA     (RDATA)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int            m_owner = -1;   // granted requester, -1 when idle
  int            m_age   = 0;    // cycles since the grant started (1 = strobe cycle)
  bit            m_done  = 0;    // response (or timeout) taken: this is the VALID cycle
  bit            m_err   = 0;
  int            m_ptr   = 0;
  logic [DW-1:0] m_rdata = '0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Every negedge: compare the outputs with the model, then advance the
  // model with the inputs the next rising edge will sample.
  initial begin : cmp
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_valid;
    forever begin
      @(negedge SYSCLK);
      if (SYSRESET) begin
        m_owner = -1; m_age = 0; m_done = 0; m_err = 0; m_ptr = 0; m_rdata = '0;
      end
      e_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_valid = m_done ? e_gnt : '0;
      chk("gnt",       GNT,       e_gnt);
      chk("valid",     VALID,     e_valid);
      chk("busy",      BUSY,      m_owner >= 0);
      chk("contread",  contREAD,  (m_owner >= 0) && !m_done && (m_age == 1));
      chk("err",       ERR,       m_done && m_err);
      chk("rdata_out", RDATA_OUT, m_rdata);
      if (!SYSRESET) begin
        if (m_owner < 0) begin
          if (REQ != 0) begin
            m_owner = pick(REQ, m_ptr); m_age = 1; m_done = 0; m_err = 0;
          end
        end else if (m_done) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1; m_done = 0; m_err = 0;
        end else begin
          if (contWRITE) begin
            m_rdata = RDATA; m_done = 1;
          end else if (TO_EN && (m_age - 1 == TIMEOUT)) begin
            m_rdata = '1; m_done = 1; m_err = 1;
          end
          m_age++;
        end
      end
    end
  end

  // Advance one clock and present new inputs shortly after the edge.
  task automatic step(input logic [N-1:0] r, input logic w, input logic [DW-1:0] d);
    @(posedge SYSCLK);
    #2;
    REQ = r; contWRITE = w; RDATA = d;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge SYSCLK); #2;
    SYSRESET = 1'b1; REQ = '0; contWRITE = 1'b0;
    repeat (cycles) step('0, 1'($urandom_range(0, 1)), $urandom);
    @(posedge SYSCLK); #2;
    SYSRESET = 1'b0; contWRITE = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nread, nvalid, k, seen;
    logic [DW-1:0] d;

    // Reset held 10 cycles with stray contWRITE pulses.
    do_reset(10);
    chk("reset_busy", BUSY, 1'b0);
    step('0, 1'b1, 32'h1111_2222);
    step('0, 1'b0, '0);
    chk("idle_write_ignored", RDATA_OUT, 32'h0);

    // Single request, response two cycles after the strobe.
    step(4'b0100, 1'b0, '0);
    step(4'b0100, 1'b0, '0);
    chk("t2_gnt", GNT, 4'b0100);
    chk("t2_read", contREAD, 1'b1);
    step(4'b0100, 1'b0, '0);
    chk("t2_wait_read", contREAD, 1'b0);
    step(4'b0100, 1'b1, 32'hA5A5_0001);
    step(4'b0000, 1'b0, '0);
    chk("t2_valid", VALID, 4'b0100);
    chk("t2_rdata", RDATA_OUT, 32'hA5A5_0001);

    // Wrap from ptr=3 with a same-cycle response, then grant 0.
    step(4'b1001, 1'b0, '0);
    chk("t4_idle", BUSY, 1'b0);
    step(4'b1001, 1'b1, 32'h1234_5678);
    chk("t4_gnt3", GNT, 4'b1000);
    step(4'b1001, 1'b0, '0);
    chk("t4_valid3", VALID, 4'b1000);
    chk("t4_rdata", RDATA_OUT, 32'h1234_5678);
    step(4'b1001, 1'b0, '0);
    step(4'b0000, 1'b0, '0);
    chk("t4_gnt0", GNT, 4'b0001);
    step(4'b0000, 1'b1, 32'hCAFE_0002);
    step(4'b0000, 1'b0, '0);
    chk("drop_valid", VALID, 4'b0001);
    step(4'b0000, 1'b1, 32'hDEAD_BEEF);
    step(4'b0000, 1'b0, '0);
    chk("hold_rdata", RDATA_OUT, 32'hCAFE_0002);

    // Fairness: all requesting for 8 transactions.
    do_reset(2);
    nread = 0; nvalid = 0;
    for (int c = 0; c < 400 && nread < 8; c++) begin
      @(posedge SYSCLK); #2;
      if (contREAD) begin
        chk("rr_order", oh2idx(GNT), nread % N);
        nread++;
      end
      if (VALID != 0) nvalid++;
      REQ = 4'b1111;
      contWRITE = BUSY && (VALID == 0) && ($urandom_range(0, 2) == 0);
      RDATA = $urandom;
    end
    chk("rr_reads", nread, 8);
    for (int c = 0; c < 40 && BUSY; c++) begin
      @(posedge SYSCLK); #2;
      if (VALID != 0) nvalid++;
      REQ = '0; contWRITE = 1'b1; RDATA = $urandom;
    end
    chk("rr_valids", nvalid, 8);

    // Reset in the middle of WAIT.
    step(4'b0010, 1'b0, '0);
    step(4'b0010, 1'b0, '0);
    step(4'b0010, 1'b0, '0);
    chk("t5_wait_gnt", GNT, 4'b0010);
    #1 SYSRESET = 1'b1;
    #1;
    chk("t5_gnt", GNT, 4'b0000);
    chk("t5_read", contREAD, 1'b0);
    chk("t5_busy", BUSY, 1'b0);
    step('0, 1'b1, '0);
    step('0, 1'b0, '0);
    @(posedge SYSCLK); #2;
    SYSRESET = 1'b0; REQ = 4'b0011; contWRITE = 1'b0;
    step(4'b0011, 1'b1, 32'h0BAD_F00D);
    chk("t5_ptr0", GNT, 4'b0001);
    step('0, 1'b0, '0);
    step('0, 1'b0, '0);

    // No response at all.
    step(4'b0001, 1'b0, '0);
`ifdef CONT_ARB_TIMEOUT_EN
    seen = 0;
    for (k = 1; k <= 30 && seen == 0; k++) begin
      step(4'b0000, 1'b0, '0);
      if (VALID != 0) begin
        seen = k;
        chk("to_valid", VALID, 4'b0001);
        chk("to_err", ERR, 1'b1);
        chk("to_rdata", RDATA_OUT, 32'hFFFF_FFFF);
      end
    end
    chk("to_latency", seen, TIMEOUT + 2);
    step('0, 1'b0, '0);
    // Response on the very cycle the counter reaches TIMEOUT wins.
    step(4'b0001, 1'b0, '0);
    for (k = 1; k <= TIMEOUT + 1; k++) begin
      d = 32'h5A5A_0000 + DW'(k);
      step(4'b0000, (k == TIMEOUT + 1), d);
    end
    step('0, 1'b0, '0);
    chk("race_valid", VALID, 4'b0001);
    chk("race_err", ERR, 1'b0);
    chk("race_rdata", RDATA_OUT, 32'h5A5A_0000 + DW'(TIMEOUT + 1));
    step('0, 1'b0, '0);
`else
    seen = 0;
    for (k = 0; k < 100; k++) begin
      step(4'b0000, 1'b0, '0);
      if (!BUSY) seen++;
    end
    chk("block_busy_drops", seen, 0);
    chk("block_gnt", GNT, 4'b0001);
    do_reset(2);
`endif

    // Randomized traffic, including occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      @(posedge SYSCLK); #2;
      SYSRESET  = ($urandom_range(0, 199) == 0);
      REQ       = N'($urandom);
      contWRITE = ($urandom_range(0, 3) == 0);
      RDATA     = $urandom;
    end
    @(posedge SYSCLK); #2;
    SYSRESET = 1'b0;
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
